simon_iter_core: RTL and testbench

SIMON_ITER_CORE -- requirements
Module: simon_iter_core

---
 rtl/simon_pkg.sv | 45 ++++
 rtl/simon_round.sv | 37 +++
 rtl/simon_iter_core.sv | 162 ++++++++++++++++
 tb/tb_simon_iter_core.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// simon_pkg
//   Shared definitions for the iterative SIMON core:
//     - simon_state_t : controller states
//     - Z_SEQ         : the five 62-bit z sequences, Z_SEQ[j][i] is bit i of z_j
//     - simon_cfg()   : maps (N, M) to round count T and z-sequence index ZI;
//                       ok = 0 flags an unsupported pair
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    READY,
    RUN,
    DONE
  } simon_state_t;

  localparam int unsigned Z_LEN = 62;

  // Ascending range: the leftmost literal bit is sequence element 0.
  localparam logic [0:61] Z_SEQ [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  typedef struct packed {
    int unsigned t;
    int unsigned zi;
    logic        ok;
  } simon_cfg_t;

  function automatic simon_cfg_t simon_cfg(input int unsigned n, input int unsigned m);
    simon_cfg_t c;
    c = '{t: 0, zi: 0, ok: 1'b0};
    if      (n == 16 && m == 4) c = '{t: 32, zi: 0, ok: 1'b1};
    else if (n == 24 && m == 3) c = '{t: 36, zi: 0, ok: 1'b1};
    else if (n == 24 && m == 4) c = '{t: 36, zi: 1, ok: 1'b1};
    else if (n == 32 && m == 3) c = '{t: 42, zi: 2, ok: 1'b1};
    else if (n == 32 && m == 4) c = '{t: 44, zi: 3, ok: 1'b1};
    return c;
  endfunction

endpackage

// File: rtl/simon_round.sv
// simon_round
//   One combinational SIMON round, shared by encrypt and decrypt.
//   Ports:
//     i_mode : 0 = encrypt round, 1 = decrypt (inverse) round
//     i_x/i_y: current state words
//     i_k    : round key for this round
//     o_x/o_y: next state words
module simon_round #(
  parameter int unsigned N = 16
) (
  input  logic         i_mode,
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  input  logic [N-1:0] i_k,
  output logic [N-1:0] o_x,
  output logic [N-1:0] o_y
);

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned r);
    return (v << r) | (v >> (N - r));
  endfunction

  function automatic logic [N-1:0] f(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  always_comb begin
    if (!i_mode) begin
      o_x = i_y ^ f(i_x) ^ i_k;
      o_y = i_x;
    end else begin
      o_x = i_y;
      o_y = i_x ^ f(i_y) ^ i_k;
    end
  end

endmodule

// File: rtl/simon_iter_core.sv
// simon_iter_core
//   Iterative SIMON block cipher, one round per clock, with on-chip key
//   expansion into a T x N round-key file.
//   Ports:
//     clk, rst                 : clock, asynchronous active-low reset
//     key_in/key_valid/key_ready : master key load (k0 in the low word)
//     din/mode/din_valid/din_ready : input block {x, y} and direction
//     dout/dout_valid/dout_ready : result block {x, y}
//     busy                     : high while expanding a key or running rounds
module simon_iter_core
  import simon_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned M = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M*N-1:0] key_in,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [2*N-1:0] din,
  input  logic           mode,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [2*N-1:0] dout,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic           busy
);

  localparam simon_cfg_t CFG = simon_cfg(N, M);
  localparam int unsigned T  = CFG.t;
  localparam int unsigned ZI = CFG.zi;
  localparam int unsigned IW = $clog2(T);

  localparam logic [IW-1:0] KX_LAST  = IW'(T - M - 1);
  localparam logic [IW-1:0] RUN_LAST = IW'(T - 1);

  if (!CFG.ok) begin : g_bad_cfg
    $error("simon_iter_core: unsupported N/M combination");
  end

  simon_state_t  r_state;
  simon_state_t  w_state_nxt;
  logic [N-1:0]  r_rk [T];
  logic [IW-1:0] r_cnt;
  logic [N-1:0]  r_x;
  logic [N-1:0]  r_y;
  logic          r_mode;
  logic [2*N-1:0] r_dout;
  logic          r_key_loaded;

  logic [N-1:0]  w_tmp;
  logic [N-1:0]  w_knew;
  logic          w_zbit;
  logic [IW-1:0] w_kidx;
  logic [N-1:0]  w_rkey;
  logic [N-1:0]  w_xn;
  logic [N-1:0]  w_yn;
  logic          w_key_xfer;
  logic          w_din_xfer;

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned r);
    return (v >> r) | (v << (N - r));
  endfunction

  // Key schedule step for index i = r_cnt; T-M never exceeds 62, so
  // i mod 62 is just i.
  always_comb begin
    w_tmp = ror(r_rk[r_cnt + IW'(M - 1)], 3);
    if (M == 4) w_tmp = w_tmp ^ r_rk[r_cnt + IW'(1)];
    w_zbit = Z_SEQ[ZI][6'(r_cnt)];
    w_knew = ~r_rk[r_cnt] ^ w_tmp ^ ror(w_tmp, 1) ^ N'(w_zbit) ^ N'(3);
  end

  // Decrypt walks the key file backwards with the same up-counter.
  assign w_kidx = r_mode ? (RUN_LAST - r_cnt) : r_cnt;
  assign w_rkey = r_rk[w_kidx];

  simon_round #(.N(N)) u_round (
    .i_mode (r_mode),
    .i_x    (r_x),
    .i_y    (r_y),
    .i_k    (w_rkey),
    .o_x    (w_xn),
    .o_y    (w_yn)
  );

  always_comb begin
    w_state_nxt = r_state;
    key_ready   = 1'b0;
    din_ready   = 1'b0;
    dout_valid  = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) w_state_nxt = KEYEXP;
      end
      KEYEXP: begin
        busy = 1'b1;
        if (r_cnt == KX_LAST) w_state_nxt = READY;
      end
      READY: begin
        key_ready = 1'b1;
        // A pending key load takes priority over a block.
        din_ready = r_key_loaded && !key_valid;
        if (key_valid)                       w_state_nxt = KEYEXP;
        else if (din_valid && r_key_loaded)  w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == RUN_LAST) w_state_nxt = DONE;
      end
      DONE: begin
        dout_valid = 1'b1;
        if (dout_ready) w_state_nxt = READY;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_key_xfer = key_valid && key_ready;
  assign w_din_xfer = din_valid && din_ready;
  assign dout       = r_dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_mode       <= 1'b0;
      r_dout       <= '0;
      r_key_loaded <= 1'b0;
      for (int unsigned i = 0; i < T; i++) r_rk[IW'(i)] <= '0;
    end else if (w_key_xfer) begin
      for (int unsigned k = 0; k < M; k++) r_rk[IW'(k)] <= key_in[k*N +: N];
      r_cnt        <= '0;
      r_key_loaded <= 1'b0;
    end else if (w_din_xfer) begin
      r_x    <= din[2*N-1:N];
      r_y    <= din[N-1:0];
      r_mode <= mode;
      r_cnt  <= '0;
    end else if (r_state == KEYEXP) begin
      r_rk[r_cnt + IW'(M)] <= w_knew;
      r_cnt                <= r_cnt + IW'(1);
      if (r_cnt == KX_LAST) r_key_loaded <= 1'b1;
    end else if (r_state == RUN) begin
      r_x   <= w_xn;
      r_y   <= w_yn;
      r_cnt <= r_cnt + IW'(1);
      if (r_cnt == RUN_LAST) r_dout <= {w_xn, w_yn};
    end
  end

endmodule

// File: tb/tb_simon_iter_core.sv
module tb_simon_iter_core;

  // z sequences as written in the cipher definition, element 0 leftmost.
  localparam logic [61:0] TZ [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 16/4 instance
  logic [63:0] a_key;
  logic        a_kv, a_kr;
  logic [31:0] a_din;
  logic        a_mode, a_dv, a_dr;
  logic [31:0] a_dout;
  logic        a_ov, a_ordy, a_busy;

  // 32/4 instance
  logic [127:0] b_key;
  logic         b_kv, b_kr;
  logic [63:0]  b_din;
  logic         b_mode, b_dv, b_dr;
  logic [63:0]  b_dout;
  logic         b_ov, b_ordy, b_busy;

  simon_iter_core u_d16 (
    .clk(clk), .rst(rst),
    .key_in(a_key), .key_valid(a_kv), .key_ready(a_kr),
    .din(a_din), .mode(a_mode), .din_valid(a_dv), .din_ready(a_dr),
    .dout(a_dout), .dout_valid(a_ov), .dout_ready(a_ordy), .busy(a_busy)
  );

  simon_iter_core #(.N(32), .M(4)) u_d32 (
    .clk(clk), .rst(rst),
    .key_in(b_key), .key_valid(b_kv), .key_ready(b_kr),
    .din(b_din), .mode(b_mode), .din_valid(b_dv), .din_ready(b_dr),
    .dout(b_dout), .dout_valid(b_ov), .dout_ready(b_ordy), .busy(b_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] expq [$];
  logic        mon_en    = 1'b0;
  logic        prev_rst  = 1'b0;
  logic [31:0] prev_dout = '0;

  logic [63:0] mk [2][64];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] msk(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] v, input int r, input int n);
    logic [63:0] w;
    w = v & msk(n);
    return ((w << r) | (w >> (n - r))) & msk(n);
  endfunction

  function automatic logic [63:0] fr(input logic [63:0] v, input int n);
    return (rotl(v, 1, n) & rotl(v, 8, n)) ^ rotl(v, 2, n);
  endfunction

  task automatic mexpand(input int d, input logic [127:0] key, input int n,
                         input int m, input int t, input int zi);
    logic [63:0] tmp;
    for (int k = 0; k < m; k++) mk[d][k] = 64'(key >> (k * n)) & msk(n);
    for (int i = 0; i < t - m; i++) begin
      tmp = rotl(mk[d][i+m-1], n - 3, n);
      if (m == 4) tmp = tmp ^ mk[d][i+1];
      mk[d][i+m] = (~mk[d][i] ^ tmp ^ rotl(tmp, n - 1, n)
                    ^ 64'(TZ[zi][61 - (i % 62)]) ^ 64'd3) & msk(n);
    end
  endtask

  function automatic logic [127:0] mcrypt(input int d, input logic [127:0] blk,
                                          input logic md, input int n, input int t);
    logic [63:0] x, y, tmp;
    x = 64'(blk >> n) & msk(n);
    y = 64'(blk) & msk(n);
    if (!md) begin
      for (int i = 0; i < t; i++) begin
        tmp = x; x = y ^ fr(x, n) ^ mk[d][i]; y = tmp;
      end
    end else begin
      for (int i = t - 1; i >= 0; i--) begin
        tmp = y; y = x ^ fr(y, n) ^ mk[d][i]; x = tmp;
      end
    end
    return (128'(x) << n) | 128'(y);
  endfunction

  // ---------------- per-cycle compare (16-bit instance) ----------------
  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (a_ov) begin
        if (expq.size() == 0) chk("unexpected_dout_valid", a_ov, 1'b0);
        else begin
          chk("dout", a_dout, expq[0]);
          if (a_ordy) void'(expq.pop_front());
        end
      end
      if (a_busy) chk("busy_excl", {a_kr, a_dr, a_ov}, 3'b000);
      if (a_dr)   chk("din_ready_implies_key_ready", a_kr, 1'b1);
      if (prev_rst && !a_ov) chk("dout_hold", a_dout, prev_dout);
    end
    prev_rst  <= rst;
    prev_dout <= a_dout;
  end

  // ---------------- 16-bit instance helpers ----------------
  task automatic a_wait_dr();
    int c;
    c = 0;
    while (!a_dr && c < 200) begin @(negedge clk); c++; end
    chk("din_ready_wait", a_dr, 1'b1);
  endtask

  task automatic a_busy_count(input int expc);
    int c;
    c = 0;
    @(negedge clk);
    while (a_busy && c < 200) begin c++; @(negedge clk); end
    chk("keyexp_cycles", c, expc);
  endtask

  task automatic a_load_key(input logic [63:0] k);
    int c;
    c = 0;
    while (!a_kr && c < 200) begin @(negedge clk); c++; end
    chk("key_ready_wait", a_kr, 1'b1);
    @(posedge clk); #1 a_key = k; a_kv = 1'b1;
    @(posedge clk); #1 a_kv = 1'b0;
    mexpand(0, 128'(k), 16, 4, 32, 0);
    a_busy_count(28);
  endtask

  task automatic a_block(input logic [31:0] blk, input logic md, input int hold,
                         output logic [31:0] got);
    logic [127:0] e;
    int c;
    a_wait_dr();
    @(posedge clk); #1 a_din = blk; a_mode = md; a_dv = 1'b1;
    e = mcrypt(0, 128'(blk), md, 16, 32);
    expq.push_back(e[31:0]);
    @(posedge clk); #1 a_dv = 1'b0;
    c = 0;
    @(negedge clk);
    while (!a_ov && c < 100) begin c++; @(negedge clk); end
    chk("latency16", c, 32);
    got = a_dout;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_dout", a_dout, got);
      chk("hold_valid", a_ov, 1'b1);
      chk("hold_din_ready", a_dr, 1'b0);
    end
    @(posedge clk); #1 a_ordy = 1'b1;
    @(posedge clk); #1 a_ordy = 1'b0;
    @(negedge clk);
    chk("release_valid", a_ov, 1'b0);
    chk("release_din_ready", a_dr, 1'b1);
  endtask

  // ---------------- 32-bit instance helper ----------------
  task automatic b_block(input logic [63:0] blk, input logic md, output logic [63:0] got);
    logic [127:0] e;
    int c;
    c = 0;
    while (!b_dr && c < 200) begin @(negedge clk); c++; end
    chk("b_din_ready_wait", b_dr, 1'b1);
    @(posedge clk); #1 b_din = blk; b_mode = md; b_dv = 1'b1;
    e = mcrypt(1, 128'(blk), md, 32, 44);
    @(posedge clk); #1 b_dv = 1'b0;
    c = 0;
    @(negedge clk);
    while (!b_ov && c < 100) begin c++; @(negedge clk); end
    chk("latency32", c, 44);
    got = b_dout;
    chk("b_dout_model", got, e[63:0]);
    @(posedge clk); #1 b_ordy = 1'b1;
    @(posedge clk); #1 b_ordy = 1'b0;
    @(negedge clk);
    chk("b_release_valid", b_ov, 1'b0);
  endtask

  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [127:0] r;
    logic [31:0]  g, g2, blk;
    logic [63:0]  g64, g64b, k;
    int c;

    rst = 1'b0;
    a_key = '0; a_kv = 1'b0; a_din = '0; a_mode = 1'b0; a_dv = 1'b0; a_ordy = 1'b0;
    b_key = '0; b_kv = 1'b0; b_din = '0; b_mode = 1'b0; b_dv = 1'b0; b_ordy = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout_valid", a_ov, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_din_ready", a_dr, 1'b0);
    chk("rst_dout", a_dout, 32'h0);
    chk("rst_b_dout", b_dout, 64'h0);
    chk("rst_b_din_ready", b_dr, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_key_ready", a_kr, 1'b1);
    chk("post_rst_din_ready", a_dr, 1'b0);
    chk("post_rst_b_key_ready", b_kr, 1'b1);
    mon_en = 1'b1;

    // ---- 32/4 known-answer ----
    @(posedge clk); #1 b_key = 128'h1b1a1918131211100b0a090803020100; b_kv = 1'b1;
    @(posedge clk); #1 b_kv = 1'b0;
    mexpand(1, b_key, 32, 4, 44, 3);
    c = 0;
    @(negedge clk);
    while (b_busy && c < 200) begin c++; @(negedge clk); end
    chk("b_keyexp_cycles", c, 40);
    r = mcrypt(1, 128'h656b696c20646e75, 1'b0, 32, 44);
    chk("model_kat32", r[63:0], 64'h44c8fc20b9dfa07a);
    b_block(64'h656b696c20646e75, 1'b0, g64);
    chk("kat32_enc", g64, 64'h44c8fc20b9dfa07a);
    b_block(g64, 1'b1, g64b);
    chk("kat32_dec", g64b, 64'h656b696c20646e75);

    // ---- 16/4 known-answer, decrypt with 10-cycle back-pressure ----
    a_load_key(64'h1918111009080100);
    r = mcrypt(0, 128'h65656877, 1'b0, 16, 32);
    chk("model_kat16", r[31:0], 32'hc69be9bb);
    a_block(32'h65656877, 1'b0, 0, g);
    chk("kat16_enc", g, 32'hc69be9bb);
    a_block(32'hc69be9bb, 1'b1, 10, g);
    chk("kat16_dec", g, 32'h65656877);

    // ---- random round trips ----
    for (int i = 0; i < 6; i++) begin
      blk = $urandom;
      a_block(blk, 1'b0, int'($urandom_range(0, 3)), g);
      a_block(g, 1'b1, int'($urandom_range(0, 3)), g2);
      chk("roundtrip", g2, blk);
    end

    // ---- random key, random modes ----
    a_load_key({$urandom, $urandom});
    for (int i = 0; i < 4; i++)
      a_block($urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), g);

    // ---- key and block offered together in READY ----
    a_wait_dr();
    k = {$urandom, $urandom};
    @(posedge clk); #1 a_key = k; a_kv = 1'b1; a_din = $urandom; a_mode = 1'b0; a_dv = 1'b1;
    @(negedge clk);
    chk("both_din_ready", a_dr, 1'b0);
    chk("both_key_ready", a_kr, 1'b1);
    @(posedge clk); #1 a_kv = 1'b0; a_dv = 1'b0;
    mexpand(0, 128'(k), 16, 4, 32, 0);
    a_busy_count(28);
    chk("both_no_valid", a_ov, 1'b0);
    a_block($urandom, 1'b0, 1, g);
    a_block($urandom, 1'b1, 0, g);

    // ---- reset at round 10 of RUN ----
    a_wait_dr();
    @(posedge clk); #1 a_din = $urandom; a_mode = 1'b0; a_dv = 1'b1;
    @(posedge clk); #1 a_dv = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_dout_valid", a_ov, 1'b0);
    chk("abort_busy", a_busy, 1'b0);
    chk("abort_din_ready", a_dr, 1'b0);
    chk("abort_dout", a_dout, 32'h0);
    @(posedge clk); #1 rst = 1'b1; a_dv = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("abort_no_din_ready", a_dr, 1'b0);
      chk("abort_no_valid", a_ov, 1'b0);
    end
    a_dv = 1'b0;
    a_load_key(k);
    a_block($urandom, 1'b0, 0, g);

    repeat (3) @(negedge clk);
    chk("queue_drained", 128'(expq.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
